// File: rtl/uart_rx_oversampled.sv
// Oversampled 8N1-style UART receiver driven by an external OVERSAMPLE x baud tick.
// Recovers frames from rx and pulses valid (good stop) or frame_err (stop low).
module uart_rx_oversampled #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 busy
);
  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CW-1:0] HALF  = CW'(OVERSAMPLE/2 - 1);
  localparam logic [CW-1:0] FULL  = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LASTB = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

  state_t               state, state_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic [BW-1:0]        bidx, bidx_n;
  logic [DATA_BITS-1:0] sh, sh_n, data_n;
  logic                 valid_n, ferr_n;
  logic                 rx_m, rx_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      bidx      <= '0;
      sh        <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      bidx      <= bidx_n;
      sh        <= sh_n;
      data      <= data_n;
      valid     <= valid_n;
      frame_err <= ferr_n;
    end
  end

  // Pulses default low every clk so they never outlive one cycle, even with tick stalled.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bidx_n  = bidx;
    sh_n    = sh;
    data_n  = data;
    valid_n = 1'b0;
    ferr_n  = 1'b0;
    if (tick) begin
      cnt_n = cnt + 1'b1;
      unique case (state)
        IDLE: begin
          cnt_n = '0;
          if (!rx_s) state_n = START;
        end
        START: if (cnt == HALF) begin
          cnt_n   = '0;
          bidx_n  = '0;
          state_n = rx_s ? IDLE : DATA;
        end
        DATA: if (cnt == FULL) begin
          cnt_n = '0;
          sh_n  = {rx_s, sh[DATA_BITS-1:1]};
          if (bidx == LASTB) begin
            bidx_n  = '0;
            state_n = STOP;
          end else begin
            bidx_n = bidx + 1'b1;
          end
        end
        STOP: if (cnt == FULL) begin
          cnt_n  = '0;
          data_n = sh;
          if (rx_s) begin
            valid_n = 1'b1;
            state_n = IDLE;
          end else begin
            ferr_n  = 1'b1;
            state_n = BRK;
          end
        end
        BRK: begin
          // Held-low line must go idle before a new start bit is accepted.
          cnt_n = '0;
          if (rx_s) state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // START only counts as busy once its first tick has elapsed.
  assign busy = (state == START) ? (cnt != '0) : (state != IDLE);

endmodule

// File: doc/uart_rx_oversampled.md
# uart_rx_oversampled

- Serial receiver that consumes the periodic one-cycle strobe from the team's tick counter, configured for OVERSAMPLE × baud rate.
- Recovers 8N1-style asynchronous frames from the `rx` line and presents each received word as a one-cycle `valid` pulse with parallel `data`.
- Sits behind the board UART pin and feeds the RSA datapath input (key/message bytes).
- All state advances only on cycles where `tick` is high.

## Interface
- DATA_BITS, 8, payload bits per frame, LSB first
- OVERSAMPLE, 16, ticks per bit period; even, ≥ 4
- clk  input  1  system clock; all logic on rising edge
- rst_n  input  1  asynchronous, active-low reset
- tick  input  1  one-clk strobe at OVERSAMPLE × baud (tick counter output)
- rx  input  1  asynchronous serial line, idle high
- data  output  DATA_BITS  last received word; held until the next frame completes
- valid  output  1  one-clk pulse: `data` updated with a good frame
- frame_err  output  1  one-clk pulse: stop bit sampled low
- busy  output  1  high from confirmed start bit until return to IDLE

## Operation
- **Synchronizer:** `rx` passes through two flip-flops (`rx_s`). Both reset to 1. All decisions use `rx_s`.
- **Counters:**
  - Sample counter: $clog2(OVERSAMPLE) bits.
  - Bit index: $clog2(DATA_BITS) bits.
  - Both clear on every state change.
- **States:** IDLE, START, DATA, STOP, BREAK.
- **IDLE:**
  - On a tick with `rx_s`=0: go to START, sample counter = 0.
- **START:**
  - Count ticks. On the tick where the counter reaches OVERSAMPLE/2−1 (mid start bit), sample `rx_s`.
  - If `rx_s`=1: glitch. Return to IDLE with no output.
  - If `rx_s`=0: go to DATA, counter = 0, bit index = 0.
- **DATA:**
  - On the tick where the counter reaches OVERSAMPLE−1 (mid bit), shift `rx_s` into the MSB of the shift register (right shift, LSB first), then increment the bit index.
  - After bit DATA_BITS−1, go to STOP.
- **STOP:**
  - At mid stop bit (OVERSAMPLE−1 ticks), sample `rx_s`.
  - If 1: `data` ← shift register, `valid` pulses, go to IDLE.
  - If 0: `data` ← shift register, `frame_err` pulses, `valid` stays low, go to BREAK.
- **BREAK:**
  - Wait for a tick with `rx_s`=1, then go to IDLE. Prevents a held-low line from producing repeated frames.
- **busy:** 1 in DATA, STOP and BREAK, and in START after the first tick. 0 in IDLE.
- **Simultaneous events:**
  - A new falling edge is only recognised in IDLE. STOP exits at mid stop bit, so back-to-back frames with one stop bit are received.
- **Reset** (any time, including mid-frame):
  - State = IDLE; counters = 0; shift register = 0.
  - `data` = 0, `valid` = 0, `frame_err` = 0, `busy` = 0, synchronizer = 1.
  - A partially received frame is discarded.

## Timing
- `tick` low: no state, counter or output change. `valid` and `frame_err` are never high for more than one clk.
- `rx` to `rx_s` latency: 2 clk.
- Start detection: first tick after `rx_s` falls. Worst-case offset is one tick period.
- Sample points:
  - Start bit: OVERSAMPLE/2 ticks after detection.
  - Each subsequent bit (data, then stop): OVERSAMPLE ticks after the previous sample point.
- `valid`/`frame_err` assert on the clk edge of the stop-bit sampling tick (registered). They deassert on the next clk.
- `data` changes only on that same edge.
- Frame acceptance latency: about 9.5 bit periods from the start-bit falling edge (DATA_BITS=8), plus ≤ 1 tick plus 2 clk.
- Tolerates ±4% baud mismatch at OVERSAMPLE=16.

## Test plan
Bench setup: `tick` every 4 clk, OVERSAMPLE=16, DATA_BITS=8; the bench drives `rx` bit-accurately at 64 clk per bit.

- **Single frame:** send 0xA5 with one stop bit → exactly one `valid` pulse, `data`=0xA5, `frame_err` never high, `busy` back to 0 after the stop sample.
- **Start glitch:** pulse `rx` low for 3 ticks (12 clk) while idle → no `valid`, no `frame_err`, `busy`=0 within 8 ticks. A following 0x3C is received correctly.
- **Framing error:** send 0x3C with stop bit 0, then hold `rx` low for 20 bit times → one `frame_err` pulse, `data`=0x3C, no `valid`, no further pulses. After `rx` returns high, 0x81 is received with `valid`.
- **Back-to-back:** send 0x00, 0xFF, 0x55 with single stop bits and no idle gap → three `valid` pulses with `data` 0x00, 0xFF, 0x55 in order.
- **Reset mid-frame:** assert `rst_n`=0 during data bit 4 of 0xF0 → all outputs 0 immediately (asynchronous). Release, send 0x12 → `valid` with `data`=0x12.
- **Tick stall:** hold `tick` low for 200 clk in the middle of a frame, then resume → no state change during the stall. The frame is received correctly when the bench stretches `rx` to match.
